ctrl_decode_monitor: RTL

CTRL_DECODE_MONITOR -- requirements
Module: ctrl_decode_monitor

---
 rtl/ctrl_decode_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ctrl_decode_monitor.sv
// ctrl_decode_monitor: passive checker of RV32 controller outputs against opcode-derived expectations
module ctrl_decode_monitor #(
    parameter int         LATENCY    = 1,
    parameter int         CNT_W      = 16,
    parameter logic [6:0] CHECK_MASK = 7'h7F
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    input  logic             reg_wr,
    input  logic             sel_A,
    input  logic             sel_B,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [1:0]       wb_sel,
    input  logic             err_clr,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             err_sticky,
    output logic [31:0]      first_err_instr,
    output logic [5:0]       first_err_vec
);
    // exp packs {wb_sel[1:0], wr_en, rd_en, sel_B, sel_A, reg_wr}; care has one bit per field
    typedef struct packed {
        logic        chk;
        logic        ill;
        logic [6:0]  exp;
        logic [5:0]  care;
        logic [31:0] instr;
    } slot_t;

    typedef enum logic {IDLE_OK, ERR_HELD} state_t;

    state_t     state, state_nx;
    slot_t      cur, cmp;
    logic [6:0] cls;
    logic [6:0] act;
    logic [5:0] diff;
    logic       mismatch;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
        return v + CNT_W'(inc && !(&v));
    endfunction

    // decode the presented instruction into its class and expected controller vector
    always_comb begin
        cls       = '0;
        cur       = '0;
        cur.care  = 6'h3F;
        cur.instr = instruction;
        case (instruction[6:0])
            7'b0110011: begin cls[0] = 1'b1; cur.exp = 7'b0000011; end
            7'b0010011: begin cls[1] = 1'b1; cur.exp = 7'b0000111; end
            7'b0000011: begin cls[2] = 1'b1; cur.exp = 7'b0101111; end
            7'b0100011: begin cls[3] = 1'b1; cur.exp = 7'b0010110; cur.care = 6'b011111; end
            7'b1100011: begin cls[4] = 1'b1; cur.exp = 7'b0000100; cur.care = 6'b011111; end
            7'b0110111: begin cls[5] = 1'b1; cur.exp = 7'b0000101; cur.care = 6'b111101; end
            7'b1101111: begin cls[6] = 1'b1; cur.exp = 7'b1000101; end
            default:    cls = '0;
        endcase
        cur.chk = instr_valid && |(cls & CHECK_MASK);
        cur.ill = instr_valid && cls == '0;
    end

    generate
        if (LATENCY == 0) begin : g_direct
            assign cmp = cur;
        end else begin : g_pipe
            slot_t pipe [LATENCY];
            // delay line: one slot per cycle, bubbles travel as empty slots, reset drops everything in flight
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= cur;
                    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign cmp = pipe[LATENCY-1];
        end
    endgenerate

    assign act        = {wb_sel, wr_en, rd_en, sel_B, sel_A, reg_wr};
    assign diff       = {act[6:5] != cmp.exp[6:5], act[4:0] ^ cmp.exp[4:0]} & cmp.care;
    assign mismatch   = cmp.chk && |diff;
    assign err_sticky = state == ERR_HELD;

    // sticky-error state register
    always_ff @(posedge clk) begin
        state <= !reset_n ? IDLE_OK : state_nx;
    end

    // a mismatch always wins over a coincident clear
    always_comb begin
        state_nx = mismatch ? ERR_HELD : err_clr ? IDLE_OK : state;
    end

    // saturating statistics; a clear zeroes first so the same-cycle compare still counts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chk_cnt     <= '0;
            err_cnt     <= '0;
            illegal_cnt <= '0;
        end else begin
            chk_cnt     <= bump(err_clr ? '0 : chk_cnt, cmp.chk);
            err_cnt     <= bump(err_clr ? '0 : err_cnt, mismatch);
            illegal_cnt <= bump(err_clr ? '0 : illegal_cnt, cmp.ill);
        end
    end

    // capture the first failing instruction and its failing fields
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            first_err_instr <= '0;
            first_err_vec   <= '0;
        end else if (mismatch && (!err_sticky || err_clr)) begin
            first_err_instr <= cmp.instr;
            first_err_vec   <= diff;
        end else if (err_clr) begin
            first_err_instr <= '0;
            first_err_vec   <= '0;
        end
    end
endmodule
